// File: rtl/ysyx_22040386_pkg.sv
// Shared GPR write-back constants and types for the ysyx_22040386 core slice.
package ysyx_22040386_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned CNT_WIDTH  = 2;
  localparam int unsigned STARVE_MAX = 4;

  typedef logic [ADDR_WIDTH-1:0] gpr_idx_t;

endpackage

// File: rtl/ysyx_22040386_scoreboard.sv
// Per-GPR pending-write counters: issue increments, retire decrements,
// with busy lookups for the two decode ports and a saturation flag.
import ysyx_22040386_pkg::*;

module ysyx_22040386_scoreboard #(
  parameter int unsigned ADDR_WIDTH = ysyx_22040386_pkg::ADDR_WIDTH,
  parameter int unsigned CNT_WIDTH  = ysyx_22040386_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_en,
  input  logic [ADDR_WIDTH-1:0] inc_idx,
  input  logic                  dec_en,
  input  logic [ADDR_WIDTH-1:0] dec_idx,
  input  logic [ADDR_WIDTH-1:0] idx1,
  input  logic [ADDR_WIDTH-1:0] idx2,
  output logic                  busy1,
  output logic                  busy2,
  input  logic [ADDR_WIDTH-1:0] sat_idx,
  output logic                  sat
);

  localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic                 same_idx;

  assign same_idx = inc_en && dec_en && (inc_idx == dec_idx);

  // Issue and retire to the same register in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      if (inc_en && !same_idx)
        cnt[inc_idx] <= cnt[inc_idx] + CNT_WIDTH'(1);
      if (dec_en && !same_idx && (cnt[dec_idx] != '0))
        cnt[dec_idx] <= cnt[dec_idx] - CNT_WIDTH'(1);
    end
  end

  assign busy1 = (idx1 != '0) && (cnt[idx1] != '0);
  assign busy2 = (idx2 != '0) && (cnt[idx2] != '0);
  assign sat   = &cnt[sat_idx];

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    (dec_en && !same_idx) |-> (cnt[dec_idx] != '0));

endmodule

// File: rtl/ysyx_22040386_wb_commit.sv
// Write-back commit: arbitrates ALU/LSU results onto the registered RF write
// port, tracks pending writes and exposes busy/bypass to decode.
import ysyx_22040386_pkg::*;

module ysyx_22040386_wb_commit #(
  parameter int unsigned ADDR_WIDTH = ysyx_22040386_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ysyx_22040386_pkg::DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = ysyx_22040386_pkg::CNT_WIDTH,
  parameter int unsigned STARVE_MAX = ysyx_22040386_pkg::STARVE_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  fwd1,
  output logic                  fwd2,
  output logic [DATA_WIDTH-1:0] fwd_data1,
  output logic [DATA_WIDTH-1:0] fwd_data2
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0]   starve;
  logic                  starve_hit;
  logic                  alu_grant, lsu_grant;
  logic                  ret_valid, ret_wr;
  logic [ADDR_WIDTH-1:0] ret_rd;
  logic [DATA_WIDTH-1:0] ret_data;
  logic                  sat;
  logic                  inc_en;

  assign starve_hit = (starve == STARVE_W'(STARVE_MAX));

  // LSU has priority; the ALU is forced through after STARVE_MAX straight losses.
  always_comb begin
    alu_grant = rst_n && alu_valid && (!lsu_valid || starve_hit);
    lsu_grant = rst_n && lsu_valid && !alu_grant;
    ret_valid = alu_grant || lsu_grant;
    ret_rd    = alu_grant ? alu_rd   : lsu_rd;
    ret_data  = alu_grant ? alu_data : lsu_data;
    ret_wr    = ret_valid && (ret_rd != '0);
  end

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;
  assign iss_ready = rst_n && ((iss_rd == '0) || !sat);
  assign inc_en    = iss_valid && iss_ready && (iss_rd != '0);

  always_ff @(posedge clk) begin
    if (!rst_n)
      starve <= '0;
    else if (alu_grant)
      starve <= '0;
    else if (alu_valid)
      starve <= starve + STARVE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= ret_wr;
      if (ret_wr) begin
        rf_waddr <= ret_rd;
        rf_wdata <= ret_data;
      end
    end
  end

  ysyx_22040386_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (inc_en),
    .inc_idx(iss_rd),
    .dec_en (ret_wr),
    .dec_idx(ret_rd),
    .idx1   (raddr1),
    .idx2   (raddr2),
    .busy1  (busy1),
    .busy2  (busy2),
    .sat_idx(iss_rd),
    .sat    (sat)
  );

  assign fwd1      = rf_wen && (rf_waddr == raddr1) && (raddr1 != '0);
  assign fwd2      = rf_wen && (rf_waddr == raddr2) && (raddr2 != '0);
  assign fwd_data1 = fwd1 ? rf_wdata : '0;
  assign fwd_data2 = fwd2 ? rf_wdata : '0;

endmodule

// File: tb/tb_ysyx_22040386_wb_commit.sv
// Directed bench for the write-back commit unit: reset, retire latency,
// LSU/ALU starvation pattern, counter saturation, x0 handling and mid-run reset.
module tb_ysyx_22040386_wb_commit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        lsu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [4:0]  raddr1, raddr2;
  logic        busy1, busy2, fwd1, fwd2;
  logic [63:0] fwd_data1, fwd_data2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040386_wb_commit #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(64),
    .CNT_WIDTH (2),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .busy1(busy1), .busy2(busy2), .fwd1(fwd1), .fwd2(fwd2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 64'h22;
    raddr1 = 5'd5; raddr2 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({iss_ready, alu_ready, lsu_ready} !== 3'b000) begin
        errors++; $display("FAIL reset_readies got %b exp 000", {iss_ready, alu_ready, lsu_ready}); end
      tick();
      checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", rf_wen); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", busy1); end
    end
    checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 64'd0) begin
      errors++; $display("FAIL reset_wregs got %0h/%0h exp 0/0", rf_waddr, rf_wdata); end
    iss_valid = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_retire();
    raddr1 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL single_iss_ready got %b exp 1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy_set got %b exp 1", busy1); end
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hDEAD;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %b exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 64'hDEAD) begin
      errors++; $display("FAIL single_wport got %b/%0d/%0h exp 1/7/dead", rf_wen, rf_waddr, rf_wdata); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL single_busy_clr got %b exp 0", busy1); end
    checks++; if (fwd1 !== 1'b1 || fwd_data1 !== 64'hDEAD) begin
      errors++; $display("FAIL single_fwd got %b/%0h exp 1/dead", fwd1, fwd_data1); end
    tick();
    checks++; if (rf_wen !== 1'b0 || fwd1 !== 1'b0 || fwd_data1 !== 64'd0) begin
      errors++; $display("FAIL single_idle got %b/%b/%0h exp 0/0/0", rf_wen, fwd1, fwd_data1); end
  endtask

  task automatic test_starve();
    int alu_n;
    logic exp_alu;
    logic [63:0] exp_data;
    logic [4:0]  exp_addr;
    alu_n = 0;
    iss_valid = 1'b1; iss_rd = 5'd3; tick();
    iss_rd = 5'd4; tick();
    for (int k = 0; k < 10; k++) begin
      exp_alu   = ((k % 5) == 4);
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3000 + 64'(alu_n);
      lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h4000 + 64'(k);
      iss_valid = 1'b1; iss_rd = exp_alu ? 5'd3 : 5'd4;
      exp_data  = exp_alu ? 64'h3000 + 64'(alu_n) : 64'h4000 + 64'(k);
      exp_addr  = exp_alu ? 5'd3 : 5'd4;
      #1;
      checks++; if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
        errors++; $display("FAIL starve_grant k=%0d got alu=%b lsu=%b exp alu=%b", k, alu_ready, lsu_ready, exp_alu); end
      tick();
      checks++; if (rf_wen !== 1'b1 || rf_waddr !== exp_addr || rf_wdata !== exp_data) begin
        errors++; $display("FAIL starve_wport k=%0d got %b/%0d/%0h exp 1/%0d/%0h", k, rf_wen, rf_waddr, rf_wdata, exp_addr, exp_data); end
      if (exp_alu) alu_n++;
    end
    iss_valid = 1'b0; alu_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 64'h4444;
    tick();
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h3333;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL starve_alu_alone got %b exp 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL starve_drained got %b/%b exp 0/0", busy1, busy2); end
    checks++; if (rf_wdata !== 64'h3333 || fwd1 !== 1'b1) begin
      errors++; $display("FAIL starve_last got %0h/%b exp 3333/1", rf_wdata, fwd1); end
  endtask

  task automatic test_saturation();
    raddr1 = 5'd9;
    for (int i = 0; i < 3; i++) begin
      iss_valid = 1'b1; iss_rd = 5'd9;
      #1;
      checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_fill%0d got %b exp 1", i, iss_ready); end
      tick();
    end
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h99;
    #1;
    checks++; if (iss_ready !== 1'b0 || lsu_ready !== 1'b1) begin
      errors++; $display("FAIL sat_full got iss=%b lsu=%b exp 0/1", iss_ready, lsu_ready); end
    tick();
    lsu_valid = 1'b0;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sat_freed got %b exp 1", iss_ready); end
    checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h99) begin
      errors++; $display("FAIL sat_wport got %b/%0d/%0h exp 1/9/99", rf_wen, rf_waddr, rf_wdata); end
    iss_valid = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sat_busy got %b exp 1", busy1); end
  endtask

  task automatic test_x0();
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h55;
    #1;
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_lsu_ready got %b exp 1", lsu_ready); end
    tick();
    lsu_valid = 1'b0;
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL x0_wen got %b exp 0", rf_wen); end
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got %b exp 1", iss_ready); end
    tick();
    iss_valid = 1'b0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0 || fwd1 !== 1'b0) begin
      errors++; $display("FAIL x0_busy got %b/%b/%b exp 0/0/0", busy1, busy2, fwd1); end
  endtask

  task automatic test_same_cycle_and_reset();
    raddr1 = 5'd12; raddr2 = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd12;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC0DE;
    #1;
    checks++; if (iss_ready !== 1'b1 || alu_ready !== 1'b1) begin
      errors++; $display("FAIL same_readies got %b/%b exp 1/1", iss_ready, alu_ready); end
    tick();
    iss_valid = 1'b0; alu_valid = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b1 || fwd1 !== 1'b1 || fwd_data1 !== 64'hC0DE) begin
      errors++; $display("FAIL same_busy_fwd got %b/%b/%0h exp 1/1/c0de", busy1, fwd1, fwd_data1); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL same_busy9 got %b exp 1", busy2); end
    rst_n = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hBAD;
    iss_valid = 1'b1; iss_rd = 5'd12;
    #1;
    checks++; if (alu_ready !== 1'b0 || iss_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_readies got %b/%b exp 0/0", alu_ready, iss_ready); end
    tick();
    rst_n = 1'b1; alu_valid = 1'b0; iss_valid = 1'b0;
    #1;
    checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      errors++; $display("FAIL midrst_busy got %b/%b exp 0/0", busy1, busy2); end
    checks++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 64'd0 || fwd1 !== 1'b0) begin
      errors++; $display("FAIL midrst_wport got %b/%0d/%0h/%b exp 0/0/0/0", rf_wen, rf_waddr, rf_wdata, fwd1); end
    tick();
    checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL midrst_nowrite got %b exp 1'b0", rf_wen); end
  endtask

  initial begin
    test_reset();
    test_single_retire();
    test_starve();
    test_saturation();
    test_x0();
    test_same_cycle_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
